packet_assembler: RTL and testbench
===================================

# packet_assembler

Parametrised frame-assembly buffer. Collects a stream of DATA_W-bit packets into one NUM_PKT-slot data buffer, and closes the frame on a last-packet flag or when the buffer is full. On close it pulses a received-data event and presents the buffer on a valid/ready output. A level-enabled wrapping counter tracks delivered frames. It sits between a packet source and any consumer that needs a whole frame as one word.

## Interface
- DATA_W, 8, packet width in bits (≥1)
- NUM_PKT, 4, slots per frame (≥1)
- CNT_W, $clog2(NUM_PKT+1), width of buf_count
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- in_valid  input  1  packet offered
- in_ready  output  1  packet accepted when in_valid && in_ready
- in_data  input  DATA_W  packet payload
- in_last  input  1  last packet of frame, qualified by in_valid
- buf_valid  output  1  assembled frame available
- buf_ready  input  1  consumer takes frame when buf_valid && buf_ready
- buf_data  output  NUM_PKT*DATA_W  frame; packet 0 in MSB slot
- buf_count  output  CNT_W  number of packets stored (1..NUM_PKT)
- buf_trunc  output  1  frame closed full without in_last; excess beats discarded
- received_data  output  1  one-cycle pulse when a frame closes
- count_enable  input  1  level enable for frame_count
- frame_count  output  16  delivered-frame counter, wraps

## Operation
- FSM states: COLLECT, HOLD, DRAIN. Reset state is COLLECT.
- COLLECT: in_ready=1. An accepted beat writes slot idx (bits [(NUM_PKT-idx)*DATA_W-1 -: DATA_W]), then idx++.
  - If the beat has in_last: close the frame with buf_count=idx+1 and buf_trunc=0. Unwritten slots read as 0.
  - Else if idx==NUM_PKT-1: close the frame with buf_count=NUM_PKT and buf_trunc=1, and set drain_pending.
- Close: next state HOLD. buf_valid=1 and received_data=1 for exactly one cycle. idx resets to 0.
- HOLD: in_ready=0. buf_data, buf_count and buf_trunc are held stable. On buf_valid && buf_ready, go to DRAIN if drain_pending, else to COLLECT.
  - frame_count increments by 1 on that handshake only when count_enable=1. 16'hFFFF wraps to 0.
- DRAIN: in_ready=1. Accepted beats are discarded. The beat with in_last returns the FSM to COLLECT and clears drain_pending.
- in_last without in_valid is ignored. in_data and in_last are don't-care when not accepted.
- Buffer slots are cleared at the start of each frame, so no stale data appears in a short frame.
- NUM_PKT=1: every accepted beat closes a frame. buf_trunc=1 if in_last=0.
- Reset mid-frame or mid-HOLD: partial or held frame is dropped, no received_data pulse, frame_count=0.

## Timing
- Reset values: in_ready=0, buf_valid=0, buf_data=0, buf_count=0, buf_trunc=0, received_data=0, frame_count=0, idx=0.
- All outputs are registered.
- in_ready rises at the first rising edge after reset deasserts.
- Closing beat accepted at edge k:
  - buf_valid, buf_data, received_data are high after edge k.
  - in_ready is low after edge k.
  - received_data is low after edge k+1.
- Output handshake at edge m:
  - buf_valid low after m.
  - in_ready high after m (COLLECT or DRAIN).
  - frame_count updated after m.
- Minimum frame period is N beats + 1 cycle when the consumer holds buf_ready=1.
- buf_ready asserted while buf_valid=0 has no effect. buf_valid never drops without a handshake, except on reset.

## Structure
- Shared package packet_assembler_pkg holds:
  - typedef enum state_t {COLLECT, HOLD, DRAIN}
  - localparam FRAME_CNT_W=16
- Sub-module frame_counter (WIDTH param; inputs clock, reset, inc, enable; output count) implements the level-enabled wrapping counter. It is instantiated once.

## Test plan
- Full frame: 4 beats A1,B2,C3,D4 with last on beat 4, buf_ready=1, count_enable=1 -> buf_data=32'hA1B2C3D4, buf_count=4, trunc=0, one received_data pulse, frame_count=1.
- Short frame: 2 beats 11,22 with last on beat 2 -> buf_data=32'h11220000, buf_count=2, trunc=0.
- Truncation: 6 beats 01..06 with last on beat 6 -> buf_data=32'h01020304, trunc=1. Beats 05 and 06 are accepted in DRAIN and discarded. The next frame assembles correctly.
- Backpressure: buf_ready=0 for 10 cycles after close -> buf_valid and buf_data stable, in_ready=0, received_data high exactly one cycle. Handshake on cycle 11.
- Counter: count_enable=0 on frame 2 -> frame_count stays 1. Preload the counter near 16'hFFFF -> wraps to 0.
- Reset mid-frame: reset low after 2 beats -> all outputs 0 immediately. After release, a new 4-beat frame is correct with no stale slots.

Source files
------------

// File: rtl/packet_assembler_pkg.sv
// Shared types and constants for the packet assembler.
package packet_assembler_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DRAIN
    } state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/packet_assembler_if.sv
// Packet input and frame output handshakes of the packet assembler.
interface packet_assembler_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_PKT = 4,
    parameter int CNT_W   = $clog2(NUM_PKT + 1)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      in_last;
    logic                      buf_valid;
    logic                      buf_ready;
    logic [NUM_PKT*DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]          buf_count;
    logic                      buf_trunc;

    modport master (
        output in_valid, in_data, in_last, buf_ready,
        input  in_ready, buf_valid, buf_data, buf_count, buf_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, buf_ready,
        output in_ready, buf_valid, buf_data, buf_count, buf_trunc
    );
endinterface

// File: rtl/packet_assembler_frame_counter.sv
// Level-enabled wrapping counter of delivered frames.
module frame_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && enable)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/packet_assembler.sv
// Assembles DATA_W-bit packets into one NUM_PKT-slot frame and hands it out
// on a valid/ready port; packet 0 sits in the most significant slot.
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_PKT = 4,
    parameter int CNT_W   = $clog2(NUM_PKT + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    packet_assembler_if.slave      bus,
    output logic                   received_data,
    input  logic                   count_enable,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int IDX_W = (NUM_PKT > 1) ? $clog2(NUM_PKT) : 1;
    localparam int BUF_W = NUM_PKT * DATA_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BUF_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               trunc_q, trunc_d;
    logic               drain_q, drain_d;
    logic               rcv_q, rcv_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               accept;
    logic               frame_done;

    assign accept = bus.in_valid && ready_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        count_d    = count_q;
        trunc_d    = trunc_q;
        drain_d    = drain_q;
        rcv_d      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    // Slot 0 of a new frame wipes the buffer so short frames carry zeros.
                    if (idx_q == '0)
                        data_d = '0;
                    data_d[(NUM_PKT - 1 - int'(idx_q)) * DATA_W +: DATA_W] = bus.in_data;
                    idx_d = idx_q + IDX_W'(1);
                    if (bus.in_last) begin
                        count_d = CNT_W'(idx_q) + CNT_W'(1);
                        trunc_d = 1'b0;
                        state_d = HOLD;
                    end else if (idx_q == IDX_W'(NUM_PKT - 1)) begin
                        count_d = CNT_W'(NUM_PKT);
                        trunc_d = 1'b1;
                        drain_d = 1'b1;
                        state_d = HOLD;
                    end
                    if (state_d == HOLD) begin
                        rcv_d = 1'b1;
                        idx_d = '0;
                    end
                end
            end
            HOLD: begin
                if (valid_q && bus.buf_ready) begin
                    frame_done = 1'b1;
                    state_d    = drain_q ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                if (accept && bus.in_last) begin
                    drain_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        ready_d = (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

    // NOTE: the frame buffer is reset too, because buf_data must read zero
    // while reset is low and a dropped frame must not leak into the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
            drain_q <= 1'b0;
            rcv_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            drain_q <= drain_d;
            rcv_q   <= rcv_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.buf_valid  = valid_q;
    assign bus.buf_data   = data_q;
    assign bus.buf_count  = count_q;
    assign bus.buf_trunc  = trunc_q;
    assign received_data  = rcv_q;

    frame_counter #(
        .WIDTH (FRAME_CNT_W)
    ) u_frame_counter (
        .clock  (clock),
        .reset  (reset),
        .inc    (frame_done),
        .enable (count_enable),
        .count  (frame_count)
    );

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: vector table plus hand-written
// backpressure, reset and counter-wrap sequences.
module tb_packet_assembler;
    import packet_assembler_pkg::*;

    localparam int DATA_W  = 8;
    localparam int NUM_PKT = 4;
    localparam int CNT_W   = $clog2(NUM_PKT + 1);
    localparam int BUF_W   = NUM_PKT * DATA_W;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   count_enable = 1'b0;
    logic                   received_data;
    logic [FRAME_CNT_W-1:0] frame_count;

    logic                   wrap_inc = 1'b0;
    logic                   wrap_en  = 1'b0;
    logic [FRAME_CNT_W-1:0] wrap_count;

    int tests = 0;
    int fails = 0;

    packet_assembler_if #(.DATA_W(DATA_W), .NUM_PKT(NUM_PKT), .CNT_W(CNT_W)) bus ();

    packet_assembler #(
        .DATA_W  (DATA_W),
        .NUM_PKT (NUM_PKT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .received_data (received_data),
        .count_enable  (count_enable),
        .frame_count   (frame_count)
    );

    frame_counter #(.WIDTH(FRAME_CNT_W)) u_wrap (
        .clock  (clock),
        .reset  (reset),
        .inc    (wrap_inc),
        .enable (wrap_en),
        .count  (wrap_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic                   v;
        logic [DATA_W-1:0]      d;
        logic                   l;
        logic                   br;
        logic                   ce;
        logic                   e_ir;
        logic                   e_bv;
        logic                   chk_buf;
        logic [BUF_W-1:0]       e_data;
        logic [CNT_W-1:0]       e_cnt;
        logic                   e_tr;
        logic                   e_rcv;
        logic [FRAME_CNT_W-1:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [DATA_W-1:0] d, logic l, logic br, logic ce,
                                logic ir, logic bv, logic chk, logic [BUF_W-1:0] data,
                                logic [CNT_W-1:0] cnt, logic tr, logic rcv,
                                logic [FRAME_CNT_W-1:0] fc);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.br = br; t.ce = ce;
        t.e_ir = ir; t.e_bv = bv; t.chk_buf = chk; t.e_data = data;
        t.e_cnt = cnt; t.e_tr = tr; t.e_rcv = rcv; t.e_fc = fc;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        drive(1'b1, d, l);
        @(negedge clock);
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, ".buf_valid"}, 64'(bus.buf_valid), 64'd0);
        check({tag, ".buf_data"},  64'(bus.buf_data),  64'd0);
        check({tag, ".buf_count"}, 64'(bus.buf_count), 64'd0);
        check({tag, ".buf_trunc"}, 64'(bus.buf_trunc), 64'd0);
        check({tag, ".received"},  64'(received_data), 64'd0);
        check({tag, ".frame_cnt"}, 64'(frame_count),   64'd0);
    endtask

    initial begin
        int rcv_seen;
        vec_t t;

        drive(1'b0, '0, 1'b0);
        bus.buf_ready = 1'b0;

        // Full frame, then released with count_enable=1.
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 8'hA1, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 8'hB2, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 8'hC3, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 8'hD4, 1, 1, 1, 0, 1, 1, 32'hA1B2C3D4, 3'd4, 0, 1, 16'd0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        // Short frame, held one cycle, released with count_enable=0.
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 8'h22, 1, 0, 1, 0, 1, 1, 32'h11220000, 3'd2, 0, 1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 32'h11220000, 3'd2, 0, 0, 16'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        // Truncated frame, excess beats drained, then a fresh one-beat frame.
        vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 0, 1, 1, 32'h01020304, 3'd4, 1, 1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd2));
        vecs.push_back(mk(1, 8'h05, 0, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd2));
        vecs.push_back(mk(1, 8'h06, 1, 0, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd2));
        vecs.push_back(mk(1, 8'h77, 1, 1, 1, 0, 1, 1, 32'h77000000, 3'd1, 0, 1, 16'd2));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd3));
        // in_last without in_valid is ignored.
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 16'd3));

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        check("reset.wrap_count", 64'(wrap_count), 64'd0);

        reset = 1'b1;
        #1;
        check("release.in_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        check("release.in_ready_high", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            drive(t.v, t.d, t.l);
            bus.buf_ready = t.br;
            count_enable  = t.ce;
            @(negedge clock);
            check($sformatf("vec%0d.in_ready", i),  64'(bus.in_ready),  64'(t.e_ir));
            check($sformatf("vec%0d.buf_valid", i), 64'(bus.buf_valid), 64'(t.e_bv));
            check($sformatf("vec%0d.received", i),  64'(received_data), 64'(t.e_rcv));
            check($sformatf("vec%0d.frame_cnt", i), 64'(frame_count),   64'(t.e_fc));
            if (t.chk_buf) begin
                check($sformatf("vec%0d.buf_data", i),  64'(bus.buf_data),  64'(t.e_data));
                check($sformatf("vec%0d.buf_count", i), 64'(bus.buf_count), 64'(t.e_cnt));
                check($sformatf("vec%0d.buf_trunc", i), 64'(bus.buf_trunc), 64'(t.e_tr));
            end
        end
        drive(1'b0, '0, 1'b0);
        bus.buf_ready = 1'b0;
        count_enable  = 1'b1;

        // Backpressure: frame held for 10 cycles, handshake on the 11th.
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        send_beat(8'hE3, 1'b0);
        send_beat(8'hE4, 1'b1);
        rcv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold%0d.buf_valid", i), 64'(bus.buf_valid), 64'd1);
            check($sformatf("hold%0d.buf_data", i),  64'(bus.buf_data),  64'hE1E2E3E4);
            check($sformatf("hold%0d.in_ready", i),  64'(bus.in_ready),  64'd0);
            if (received_data) rcv_seen++;
            @(negedge clock);
        end
        if (received_data) rcv_seen++;
        check("hold.received_pulses", 64'(rcv_seen), 64'd1);
        bus.buf_ready = 1'b1;
        @(negedge clock);
        bus.buf_ready = 1'b0;
        check("hold.release_valid", 64'(bus.buf_valid), 64'd0);
        check("hold.release_ready", 64'(bus.in_ready),  64'd1);
        check("hold.frame_cnt",     64'(frame_count),   64'd4);

        // Reset in the middle of a frame drops it; the next frame is clean.
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b0);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("after_reset.in_ready", 64'(bus.in_ready), 64'd1);
        bus.buf_ready = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b0);
        send_beat(8'hDD, 1'b1);
        check("after_reset.buf_valid", 64'(bus.buf_valid), 64'd1);
        check("after_reset.buf_data",  64'(bus.buf_data),  64'hAABBCCDD);
        check("after_reset.buf_count", 64'(bus.buf_count), 64'd4);
        check("after_reset.buf_trunc", 64'(bus.buf_trunc), 64'd0);
        check("after_reset.received",  64'(received_data), 64'd1);
        @(negedge clock);
        bus.buf_ready = 1'b0;
        check("after_reset.frame_cnt", 64'(frame_count), 64'd1);
        check("after_reset.released",  64'(bus.buf_valid), 64'd0);

        // Counter: disabled increments hold, then count up to 16'hFFFF and wrap.
        wrap_inc = 1'b1;
        wrap_en  = 1'b0;
        repeat (3) @(negedge clock);
        check("wrap.disabled", 64'(wrap_count), 64'd0);
        wrap_en = 1'b1;
        repeat (65535) @(negedge clock);
        check("wrap.max", 64'(wrap_count), 64'hFFFF);
        @(negedge clock);
        check("wrap.zero", 64'(wrap_count), 64'd0);
        wrap_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
